// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch stage. Holds the PC, selects the next PC,
//               reads imem and loads the IF/ID register; counts fetches/flushes.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  parameter int                 PC_W     = 32,
  parameter int                 INSTR_W  = 32,
  parameter int                 PC_STEP  = 4,
  parameter logic [PC_W-1:0]    RESET_PC = '0,
  parameter logic [INSTR_W-1:0] NOP      = '0,
  parameter int                 CNT_W    = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic [1:0]         pc_src,
  input  logic               kill,
  input  logic [PC_W-1:0]    branch_target,
  input  logic [PC_W-1:0]    jr_target,
  input  logic [PC_W-1:0]    jump_target,
  input  logic               halt_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc,
  output logic [PC_W-1:0]    ifid_pc_next,
  output logic               ifid_valid,
  output logic               halted,
  output logic [CNT_W-1:0]   fetch_count,
  output logic [CNT_W-1:0]   kill_count
);

  localparam logic [1:0] ST_BOOT   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [1:0]         r_state;
  logic [PC_W-1:0]    r_pc;
  logic [INSTR_W-1:0] r_ifid_instr;
  logic [PC_W-1:0]    r_ifid_pc;
  logic [PC_W-1:0]    r_ifid_pc_next;
  logic               r_ifid_valid;
  logic [CNT_W-1:0]   r_fetch_count;
  logic [CNT_W-1:0]   r_kill_count;

  logic [PC_W-1:0]    w_pc_inc;
  logic [PC_W-1:0]    w_target;

  // Increment wraps modulo 2^PC_W by construction.
  assign w_pc_inc = r_pc + PC_W'(PC_STEP);

  always_comb begin
    w_target = w_pc_inc;
    case (pc_src)
      2'b01:   w_target = branch_target;
      2'b10:   w_target = jr_target;
      2'b11:   w_target = jump_target;
      default: w_target = w_pc_inc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_BOOT;
      r_pc           <= RESET_PC;
      r_ifid_instr   <= NOP;
      r_ifid_pc      <= '0;
      r_ifid_pc_next <= '0;
      r_ifid_valid   <= 1'b0;
      r_fetch_count  <= '0;
      r_kill_count   <= '0;
    end else begin
      case (r_state)
        ST_BOOT: r_state <= ST_RUN;
        ST_RUN: begin
          // Kill outranks halt: a HALT seen on the wrong path must not stop fetch.
          if (kill) begin
            r_pc         <= w_target;
            r_ifid_instr <= NOP;
            r_ifid_valid <= 1'b0;
            if (r_kill_count != '1) r_kill_count <= r_kill_count + 1'b1;
          end else if (halt_req) begin
            r_state      <= ST_HALTED;
            r_ifid_instr <= NOP;
            r_ifid_valid <= 1'b0;
          end else if (!stall) begin
            r_ifid_instr   <= imem_rdata;
            r_ifid_pc      <= r_pc;
            r_ifid_pc_next <= w_pc_inc;
            r_ifid_valid   <= 1'b1;
            r_pc           <= w_target;
            if (r_fetch_count != '1) r_fetch_count <= r_fetch_count + 1'b1;
          end
        end
        default: r_state <= r_state;
      endcase
    end
  end

  assign imem_addr    = r_pc;
  assign pc           = r_pc;
  assign ifid_instr   = r_ifid_instr;
  assign ifid_pc      = r_ifid_pc;
  assign ifid_pc_next = r_ifid_pc_next;
  assign ifid_valid   = r_ifid_valid;
  assign halted       = (r_state == ST_HALTED);
  assign fetch_count  = r_fetch_count;
  assign kill_count   = r_kill_count;

endmodule
`default_nettype wire
